// File: rtl/pc_stack.sv
// Program counter with a DEPTH-level return-address stack; drives the PC
// nibble-serially onto the ROM address path in subcycles 0-2.
module pc_stack #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        cycle,
  input  logic [1:0]        pc_control,
  input  logic [2:0]        pc_write_enable,
  input  logic [1:0]        pc_next_sel,
  input  logic [3:0]        data,
  input  logic [3:0]        inst_operand,
  input  logic [3:0]        reg_value,
  output logic [3:0]        addr_nibble,
  output logic              addr_out_en,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        stack_depth,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    CTL_NONE = 2'd0,
    CTL_PUSH = 2'd1,
    CTL_POP  = 2'd2,
    CTL_RSVD = 2'd3
  } ctl_e;

  typedef enum logic [1:0] {
    SEL_DATA = 2'd0,
    SEL_INST = 2'd1,
    SEL_REG  = 2'd2,
    SEL_RSVD = 2'd3
  } sel_e;

  localparam logic [1:0] DEPTH_L = 2'(DEPTH);

  logic [ADDR_W-1:0] stack   [DEPTH];
  logic [ADDR_W-1:0] stack_d [DEPTH];
  logic [ADDR_W-1:0] base;
  logic [1:0]        depth_d;
  logic              ovf_d;
  logic              unf_d;
  logic [3:0]        src;
  ctl_e              ctl;
  sel_e              sel;

  assign ctl = ctl_e'(pc_control);
  assign sel = sel_e'(pc_next_sel);

  always_comb begin
    src = '0;
    case (sel)
      SEL_DATA: src = data;
      SEL_INST: src = inst_operand;
      SEL_REG:  src = reg_value;
      default:  src = '0;
    endcase
  end

  // Stages are applied in order on one variable: increment, then stack op, then nibble writes.
  always_comb begin
    base    = pc;
    stack_d = stack;
    depth_d = stack_depth;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (cycle == 3'd2) base = pc + ADDR_W'(1);
    case (ctl)
      CTL_PUSH: begin
        stack_d[0] = base;
        for (int unsigned i = 1; i < DEPTH; i++) stack_d[i] = stack[i-1];
        if (stack_depth == DEPTH_L) ovf_d = 1'b1;
        else depth_d = stack_depth + 2'd1;
      end
      CTL_POP: begin
        base = stack[0];
        for (int unsigned i = 0; i + 1 < DEPTH; i++) stack_d[i] = stack[i+1];
        if (stack_depth == 2'd0) unf_d = 1'b1;
        else depth_d = stack_depth - 2'd1;
      end
      default: ;
    endcase
    for (int unsigned n = 0; n < 3; n++) begin
      if (pc_write_enable[n]) base[4*n +: 4] = src;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      stack_depth <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      pc          <= base;
      stack_depth <= depth_d;
      overflow    <= ovf_d;
      underflow   <= unf_d;
      stack       <= stack_d;
    end
  end

  always_comb begin
    addr_nibble = '0;
    addr_out_en = 1'b0;
    if (reset) begin
      case (cycle)
        3'd0: begin addr_nibble = pc[3:0];  addr_out_en = 1'b1; end
        3'd1: begin addr_nibble = pc[7:4];  addr_out_en = 1'b1; end
        3'd2: begin addr_nibble = pc[11:8]; addr_out_en = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed vector bench for pc_stack: table of per-edge stimulus with
// hand-computed expectations, plus an asynchronous-reset sequence.
module tb_pc_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  cycle;
  logic [1:0]  pc_control;
  logic [2:0]  pc_write_enable;
  logic [1:0]  pc_next_sel;
  logic [3:0]  data, inst_operand, reg_value;
  logic [3:0]  addr_nibble;
  logic        addr_out_en;
  logic [11:0] pc;
  logic [1:0]  stack_depth;
  logic        overflow, underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_stack #(.DEPTH(3), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset), .cycle(cycle), .pc_control(pc_control),
    .pc_write_enable(pc_write_enable), .pc_next_sel(pc_next_sel),
    .data(data), .inst_operand(inst_operand), .reg_value(reg_value),
    .addr_nibble(addr_nibble), .addr_out_en(addr_out_en), .pc(pc),
    .stack_depth(stack_depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  cyc;
    logic [1:0]  ctl;
    logic [2:0]  we;
    logic [1:0]  sel;
    logic [3:0]  d, i, r;
    logic [3:0]  an;
    logic        aen;
    logic [11:0] pc;
    logic [1:0]  dep;
    logic        ov, un;
  } vec_t;

  vec_t vecs[$];
  int   row = 0;

  localparam int N = 0, PU = 1, PO = 2;
  localparam int D = 0, I = 1, R = 2;

  task automatic check(input string name, input int k, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic add(input int cyc, input int ctl, input int we, input int sel,
                     input int d, input int i, input int r,
                     input int an, input int aen, input int pcv, input int dep,
                     input int ov, input int un);
    vec_t v;
    v.cyc = 3'(cyc); v.ctl = 2'(ctl); v.we = 3'(we); v.sel = 2'(sel);
    v.d = 4'(d); v.i = 4'(i); v.r = 4'(r);
    v.an = 4'(an); v.aen = 1'(aen); v.pc = 12'(pcv); v.dep = 2'(dep);
    v.ov = 1'(ov); v.un = 1'(un);
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    foreach (vecs[k]) begin
      cycle = vecs[k].cyc; pc_control = vecs[k].ctl; pc_write_enable = vecs[k].we;
      pc_next_sel = vecs[k].sel; data = vecs[k].d; inst_operand = vecs[k].i;
      reg_value = vecs[k].r;
      #1;
      check("addr_nibble", row, 12'(addr_nibble), 12'(vecs[k].an));
      check("addr_out_en", row, 12'(addr_out_en), 12'(vecs[k].aen));
      @(posedge clock);
      #1;
      check("pc",          row, pc, vecs[k].pc);
      check("stack_depth", row, 12'(stack_depth), 12'(vecs[k].dep));
      check("overflow",    row, 12'(overflow), 12'(vecs[k].ov));
      check("underflow",   row, 12'(underflow), 12'(vecs[k].un));
      row++;
    end
    vecs.delete();
  endtask

  initial begin
    reset = 1'b0; cycle = 3'd0; pc_control = 2'd0; pc_write_enable = 3'd0;
    pc_next_sel = 2'd0; data = 4'd0; inst_operand = 4'd0; reg_value = 4'd0;
    #3;
    check("rst_pc",   -1, pc, 12'h000);
    check("rst_depth",-1, 12'(stack_depth), 12'h0);
    check("rst_aen",  -1, 12'(addr_out_en), 12'h0);
    check("rst_an",   -1, 12'(addr_nibble), 12'h0);
    check("rst_ov",   -1, 12'(overflow), 12'h0);
    check("rst_un",   -1, 12'(underflow), 12'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // cyc ctl we sel d i r | an aen pc dep ov un
    add(0,N,0,0,0,0,0, 0,1,'h000,0,0,0);
    add(1,N,0,0,0,0,0, 0,1,'h000,0,0,0);
    add(2,N,0,0,0,0,0, 0,1,'h001,0,0,0);
    add(3,N,0,0,0,0,0, 0,0,'h001,0,0,0);
    add(7,N,0,0,0,0,0, 0,0,'h001,0,0,0);
    add(0,N,0,0,0,0,0, 1,1,'h001,0,0,0);
    add(1,N,0,0,0,0,0, 0,1,'h001,0,0,0);
    add(2,N,0,0,0,0,0, 0,1,'h002,0,0,0);
    // preset 0xFFF, then wrap on the cycle-2 increment
    add(3,N,7,D,'hF,0,0, 0,0,'hFFF,0,0,0);
    add(0,N,0,0,0,0,0, 'hF,1,'hFFF,0,0,0);
    add(1,N,0,0,0,0,0, 'hF,1,'hFFF,0,0,0);
    add(2,N,0,0,0,0,0, 'hF,1,'h000,0,0,0);
    // JUN 0x2AB, then REG source and reserved select
    add(3,N,2,D,'hA,0,0, 0,0,'h0A0,0,0,0);
    add(4,N,1,D,'hB,0,0, 0,0,'h0AB,0,0,0);
    add(5,N,4,I,7,2,0,   0,0,'h2AB,0,0,0);
    add(6,N,1,R,0,0,5,   0,0,'h2A5,0,0,0);
    add(7,N,2,3,9,9,9,   0,0,'h205,0,0,0);
    // set pc = 0x124, JMS to 0x300
    add(3,N,1,D,3,0,0, 0,0,'h203,0,0,0);
    add(4,N,4,I,0,1,0, 0,0,'h103,0,0,0);
    add(5,N,2,R,0,0,2, 0,0,'h123,0,0,0);
    add(6,N,1,D,4,0,0, 0,0,'h124,0,0,0);
    add(0,N,0,0,0,0,0, 4,1,'h124,0,0,0);
    add(1,N,0,0,0,0,0, 2,1,'h124,0,0,0);
    add(2,PU,0,0,0,0,0, 1,1,'h125,1,0,0);
    add(3,N,4,I,0,3,0, 0,0,'h325,1,0,0);
    add(4,N,2,D,0,0,0, 0,0,'h305,1,0,0);
    add(5,N,1,D,0,0,0, 0,0,'h300,1,0,0);
    add(0,N,0,0,0,0,0, 0,1,'h300,1,0,0);
    add(1,N,0,0,0,0,0, 0,1,'h300,1,0,0);
    add(2,N,0,0,0,0,0, 3,1,'h301,1,0,0);
    add(3,PO,0,0,0,0,0, 0,0,'h125,0,0,0);
    // four pushes 0x010..0x040, overflow on the fourth
    add(4,N,7,D,0,0,0,  0,0,'h000,0,0,0);
    add(5,N,2,D,1,0,0,  0,0,'h010,0,0,0);
    add(6,PU,2,D,2,0,0, 0,0,'h020,1,0,0);
    add(7,PU,2,D,3,0,0, 0,0,'h030,2,0,0);
    add(3,PU,2,D,4,0,0, 0,0,'h040,3,0,0);
    add(4,PU,0,0,0,0,0, 0,0,'h040,3,1,0);
    add(5,N,0,0,0,0,0,  0,0,'h040,3,0,0);
    add(6,PO,0,0,0,0,0, 0,0,'h040,2,0,0);
    add(7,PO,0,0,0,0,0, 0,0,'h030,1,0,0);
    // pop during cycle 2: popped value wins over the increment
    add(2,PO,0,0,0,0,0, 0,1,'h020,0,0,0);
    // pop on empty: underflow, stack[0] still loaded, write applied on top
    add(3,PO,1,D,7,0,0, 0,0,'h027,0,0,1);
    add(4,N,0,0,0,0,0,  0,0,'h027,0,0,0);
    add(5,3,0,0,0,0,0,  0,0,'h027,0,0,0);
    add(3,N,2,D,'hA,0,0, 0,0,'h0A7,0,0,0);
    run_vecs();

    // asynchronous reset in the middle of a JUN
    cycle = 3'd4; pc_control = 2'd0; pc_write_enable = 3'd1; pc_next_sel = 2'd0; data = 4'hB;
    #2;
    reset = 1'b0;
    #1;
    check("arst_pc",    row, pc, 12'h000);
    check("arst_depth", row, 12'(stack_depth), 12'h0);
    check("arst_ov",    row, 12'(overflow), 12'h0);
    check("arst_un",    row, 12'(underflow), 12'h0);
    cycle = 3'd0;
    #1;
    check("arst_aen", row, 12'(addr_out_en), 12'h0);
    check("arst_an",  row, 12'(addr_nibble), 12'h0);
    @(posedge clock); #1;
    check("arst_hold_pc", row, pc, 12'h000);
    reset = 1'b1;
    add(0,N,0,0,0,0,0, 0,1,'h000,0,0,0);
    add(1,N,0,0,0,0,0, 0,1,'h000,0,0,0);
    add(2,N,0,0,0,0,0, 0,1,'h001,0,0,0);
    add(3,N,0,0,0,0,0, 0,0,'h001,0,0,0);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Program-address unit directly downstream of the CPU control sequencer.
- Holds the 12-bit program counter and a DEPTH-level return-address stack.
- Drives the PC nibble-serially onto the ROM address path in subcycles 0–2.
- Executes the sequencer's pc_control (push/pop), pc_write_enable and pc_next_sel commands, then advances the PC once per system cycle.

Parameters:
DEPTH, 3, number of return-address stack levels (excludes the PC itself)
ADDR_W, 12, program address width; fixed at 3 nibbles

Ports:
clock  input  1  system clock, one subcycle per edge
reset  input  1  asynchronous, active-low reset
cycle  input  3  current subcycle 0–7 from sequencer
pc_control  input  2  0 NONE, 1 PUSH, 2 POP, 3 reserved (treated as NONE)
pc_write_enable  input  3  per-nibble write: bit0 pc[3:0], bit1 pc[7:4], bit2 pc[11:8]
pc_next_sel  input  2  0 FROM_DATA, 1 FROM_INST, 2 FROM_REG, 3 reserved
data  input  4  ROM data nibble
inst_operand  input  4  instruction operand nibble from sequencer
reg_value  input  4  selected scratch-register nibble from datapath
addr_nibble  output  4  address nibble for the current subcycle
addr_out_en  output  1  high while addr_nibble is valid
pc  output  12  current program counter
stack_depth  output  2  valid stack entries, 0..DEPTH
overflow  output  1  one-clock pulse: push while full
underflow  output  1  one-clock pulse: pop while empty

Behaviour:
- Reset (reset low, asynchronous), values held until reset rises:
  - pc = 0, every stack level = 0, stack_depth = 0.
  - overflow = 0, underflow = 0, addr_out_en = 0, addr_nibble = 0.
- Reset deasserted mid system cycle: operation resumes at the next edge with the cleared state.
- Address output (combinational from cycle and pc):
  - cycle 0 → pc[3:0]; cycle 1 → pc[7:4]; cycle 2 → pc[11:8]; addr_out_en = 1 in each.
  - All other cycles: addr_out_en = 0, addr_nibble = 0.
- Edge update, evaluated in this order, result registered:
  1. base = pc.
  2. If cycle==2: base = pc+1, modulo 2^12 (0xFFF → 0x000).
  3. PUSH:
     - stack[0] ← base; stack[i] ← stack[i-1]; deepest level discarded.
     - stack_depth increments, saturating at DEPTH.
     - If depth was already DEPTH: overflow = 1 for this edge.
  4. POP:
     - base = stack[0]; stack[i] ← stack[i+1]; deepest level keeps its value.
     - stack_depth decrements, saturating at 0.
     - If depth was already 0: underflow = 1, and the pop still loads stack[0].
  5. Nibble writes: each enabled nibble of base is replaced by the source picked by pc_next_sel (data, inst_operand, reg_value; reserved value → 0).
  6. pc ← base.
- Combined effects:
  - PUSH in cycle 2 stores the incremented (return) address, then overwrites nothing.
  - A JMS push at cycle 2 followed by writes at cycles 3/4/5 therefore saves the address after the second word.
  - POP and increment in the same cycle 2: the popped value wins; no increment is applied to it.
  - Write and POP on the same edge: writes apply on top of the popped value.
- pc_next_sel is ignored when pc_write_enable == 0; unknown values must not propagate into pc.
- JIN page behaviour: pc[11:8] is never rewritten by low/mid writes. An indirect jump therefore lands in the page of the already-incremented PC.
- overflow and underflow are registered, high for exactly one clock, and cleared on every other edge.
- Latency:
  - A write/push/pop at edge N is visible on pc and stack_depth after edge N.
  - A change to pc is visible on addr_nibble from the next matching subcycle.

Test Plan:
- Reset release, then 2 system cycles of NONE → pc 0x000 → 0x001 → 0x002; addr_nibble sequence in cycle 0..2 = 1,0,0 during the second fetch.
- pc preset 0xFFF, cycle 2 edge → pc = 0x000; no flags.
- JUN: data 0xA at cycle 3 (en 010), data 0xB at cycle 4 (en 001), inst_operand 0x2 at cycle 5 (en 100, FROM_INST) → pc = 0x2AB after cycle 5.
- JMS at pc 0x124, push at cycle 2, then writes target 0x300 → stack[0] = 0x125, pc = 0x300, stack_depth = 1. POP later → pc = 0x125, stack_depth = 0.
- Four pushes of 0x010, 0x020, 0x030, 0x040 → overflow pulses on the fourth only; stack = 0x040, 0x030, 0x020; depth = 3. Pop on empty stack → underflow pulse, depth stays 0.
- reset pulled low during cycle 4 of a JUN → all outputs 0 immediately; after release, fetch restarts from 0x000.
